// File: rtl/adc_dual_spi_capture.sv
// -----------------------------------------------------------------------------
// adc_dual_spi_capture
//
// Runs one conversion frame against a dual-lane SPI ADC:
//   1. A start request in IDLE pulls adc_cs low and latches cfg_word (CONV).
//   2. The block waits for the ADC result-valid line adc_rvs, brought into the
//      clk domain through a two-flop synchronizer.
//   3. SHIFT clocks DATA_BITS serial bits. adc_sclk idles high and each bit is
//      a low half-period followed by a high half-period, each CLK_DIV clk
//      cycles long. cfg_word goes out on adc_sdi MSB first and changes on
//      falling sclk. Both ADC lanes are sampled on rising sclk.
//   4. The cycle after the last rising sclk publishes data_a/data_b with a
//      one-cycle data_valid strobe and raises adc_cs.
//   5. GAP keeps adc_cs high for CS_IDLE cycles, then the block returns to
//      IDLE. A start request that arrives while busy is dropped.
//
// Optional feature, macro ADC_RVS_TIMEOUT_EN:
//   When defined, CONV gives up after RVS_TIMEOUT cycles without a
//   synchronized adc_rvs. It then sets the sticky timeout_err flag and goes
//   straight to GAP without a data_valid strobe. The next accepted start
//   clears the flag.
//   When not defined, CONV waits indefinitely and timeout_err is tied to 0.
//
// Parameters:
//   CLK_DIV     - sclk half-period in clk cycles                  (1..255)
//   DATA_BITS   - bits per conversion frame                       (4..32)
//   CS_IDLE     - clk cycles adc_cs stays high between frames     (1..255)
//   RVS_TIMEOUT - clk cycles CONV waits for adc_rvs               (2..65535)
//
// Ports:
//   clk          in   system clock; all logic runs on its rising edge
//   rst          in   asynchronous reset, active high
//   start        in   one-cycle conversion request
//   cfg_word     in   word shifted out on adc_sdi, MSB first
//   busy         out  high whenever the FSM is not in IDLE
//   adc_cs       out  ADC chip select, active low
//   adc_sclk     out  serial clock, idle high
//   adc_sdi      out  serial data to the ADC; 0 outside SHIFT
//   adc_sdo0     in   ADC lane A serial data
//   adc_sdo1     in   ADC lane B serial data
//   adc_rvs      in   ADC result-valid (asynchronous to clk)
//   data_a       out  last captured lane A word
//   data_b       out  last captured lane B word
//   data_valid   out  one-cycle strobe when data_a/data_b update
//   timeout_err  out  sticky adc_rvs timeout flag
// -----------------------------------------------------------------------------
module adc_dual_spi_capture #(
    parameter int CLK_DIV     = 2,
    parameter int DATA_BITS   = 16,
    parameter int CS_IDLE     = 4,
    parameter int RVS_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] cfg_word,
    output logic                 busy,
    output logic                 adc_cs,
    output logic                 adc_sclk,
    output logic                 adc_sdi,
    input  logic                 adc_sdo0,
    input  logic                 adc_sdo1,
    input  logic                 adc_rvs,
    output logic [DATA_BITS-1:0] data_a,
    output logic [DATA_BITS-1:0] data_b,
    output logic                 data_valid,
    output logic                 timeout_err
);

    // -------------------------------------------------------------------------
    // Parameter legality: stop elaboration on an out-of-range setting.
    // -------------------------------------------------------------------------
    if (CLK_DIV < 1 || CLK_DIV > 255 ||
        DATA_BITS < 4 || DATA_BITS > 32 ||
        CS_IDLE < 1 || CS_IDLE > 255 ||
        RVS_TIMEOUT < 2 || RVS_TIMEOUT > 65535) begin : g_bad_params
        $error("adc_dual_spi_capture: parameter out of legal range");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // bit_cnt has to reach DATA_BITS itself, so it gets one value more than
    // the number of bits. The 8-bit counters cover the full 1..255 ranges.
    localparam int               BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]       GAP_LAST = 8'(CS_IDLE - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]           state;
    logic [7:0]           div_cnt;   // clk cycles elapsed in this sclk half
    logic [BIT_W-1:0]     bit_cnt;   // rising sclk edges so far in this frame
    logic [7:0]           gap_cnt;   // cycles spent in GAP
    logic [DATA_BITS-1:0] cfg_sh;    // latched cfg_word, consumed MSB first
    logic [DATA_BITS-1:0] sh_a;      // lane A capture shift register
    logic [DATA_BITS-1:0] sh_b;      // lane B capture shift register
    logic                 rvs_meta;
    logic                 rvs_sync;
    logic                 conv_expired;

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // adc_rvs synchronizer
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments give a real two-stage chain. Blocking
    // assignments would let adc_rvs reach rvs_sync within a single edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvs_meta <= 1'b0;
            rvs_sync <= 1'b0;
        end else begin
            rvs_meta <= adc_rvs;
            rvs_sync <= rvs_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Optional adc_rvs timeout
    // -------------------------------------------------------------------------
`ifdef ADC_RVS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(RVS_TIMEOUT - 1);

    logic [15:0] conv_cnt;
    logic        timeout_q;

    // conv_cnt holds the number of CONV cycles already spent. The exit edge is
    // therefore the end of cycle number RVS_TIMEOUT.
    assign conv_expired = (conv_cnt == TO_LAST);
    assign timeout_err  = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else if (state == IDLE && start) begin
            conv_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else if (state == CONV && !rvs_sync) begin
            if (conv_expired) begin
                timeout_q <= 1'b1;
            end else begin
                conv_cnt <= conv_cnt + 16'd1;
            end
        end
    end
`else
    assign conv_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Frame FSM and serial engine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            adc_cs     <= 1'b1;
            adc_sclk   <= 1'b1;
            adc_sdi    <= 1'b0;
            div_cnt    <= 8'd0;
            bit_cnt    <= '0;
            gap_cnt    <= 8'd0;
            cfg_sh     <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            data_a     <= '0;
            data_b     <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CONV;
                        adc_cs <= 1'b0;
                        cfg_sh <= cfg_word;
                    end
                end

                CONV: begin
                    if (rvs_sync) begin
                        // First falling sclk of the frame. The MSB is driven
                        // on the same edge.
                        state    <= SHIFT;
                        adc_sclk <= 1'b0;
                        adc_sdi  <= cfg_sh[DATA_BITS-1];
                        cfg_sh   <= cfg_sh << 1;
                        div_cnt  <= 8'd0;
                        bit_cnt  <= '0;
                    end else if (conv_expired) begin
                        state   <= GAP;
                        adc_cs  <= 1'b1;
                        gap_cnt <= 8'd0;
                    end
                end

                SHIFT: begin
                    if (!adc_sclk) begin
                        if (div_cnt == DIV_LAST) begin
                            // Rising sclk: capture both lanes on this edge.
                            adc_sclk <= 1'b1;
                            div_cnt  <= 8'd0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            sh_a     <= {sh_a[DATA_BITS-2:0], adc_sdo0};
                            sh_b     <= {sh_b[DATA_BITS-2:0], adc_sdo1};
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end else if (bit_cnt == BIT_LAST) begin
                        // This is the cycle after the final rising sclk.
                        // sclk simply stays at its idle-high level.
                        state      <= GAP;
                        adc_cs     <= 1'b1;
                        adc_sdi    <= 1'b0;
                        gap_cnt    <= 8'd0;
                        data_a     <= sh_a;
                        data_b     <= sh_b;
                        data_valid <= 1'b1;
                    end else if (div_cnt == DIV_LAST) begin
                        // Falling sclk: present the next cfg bit.
                        adc_sclk <= 1'b0;
                        div_cnt  <= 8'd0;
                        adc_sdi  <= cfg_sh[DATA_BITS-1];
                        cfg_sh   <= cfg_sh << 1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dual_spi_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_dual_spi_capture
//
// Self-checking bench for adc_dual_spi_capture. It runs table-driven frames,
// randomized frames, and hand-written sequences for the corner cases: a start
// request while busy, a reset in the middle of a frame, back-to-back frames,
// and the adc_rvs timeout (or its absence when the macro is undefined).
// A behavioural ADC model drives the lanes and records the adc_sdi stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_dual_spi_capture;

    localparam int CLK_DIV     = 2;
    localparam int DB          = 16;
    localparam int CS_IDLE     = 4;
    localparam int RVS_TIMEOUT = 100;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic [DB-1:0] cfg_word = '0;
    logic          busy;
    logic          adc_cs;
    logic          adc_sclk;
    logic          adc_sdi;
    logic          adc_sdo0 = 1'b0;
    logic          adc_sdo1 = 1'b0;
    logic          adc_rvs  = 1'b0;
    logic [DB-1:0] data_a;
    logic [DB-1:0] data_b;
    logic          data_valid;
    logic          timeout_err;

    adc_dual_spi_capture #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DB),
        .CS_IDLE    (CS_IDLE),
        .RVS_TIMEOUT(RVS_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_word   (cfg_word),
        .busy       (busy),
        .adc_cs     (adc_cs),
        .adc_sclk   (adc_sclk),
        .adc_sdi    (adc_sdi),
        .adc_sdo0   (adc_sdo0),
        .adc_sdo1   (adc_sdo1),
        .adc_rvs    (adc_rvs),
        .data_a     (data_a),
        .data_b     (data_b),
        .data_valid (data_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps to just after a falling clk edge. The monitor below has already
    // updated its view of that edge by this point.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Behavioural ADC and bus monitor, sampled on the falling clk edge
    // -------------------------------------------------------------------------
    logic [DB-1:0] word_a = '0;
    logic [DB-1:0] word_b = '0;
    logic [DB-1:0] rx_sdi = '0;
    int  bit_idx      = 0;
    int  rvs_delay    = 10;
    bit  rvs_auto     = 1'b1;
    bit  rvs_force    = 1'b0;
    int  dv_cnt       = 0;
    int  dv_total     = 0;
    int  width_err    = 0;
    int  low_len      = 0;
    int  high_len     = 0;
    bit  high_on      = 1'b0;
    int  cs_run       = 0;
    int  last_cs_low  = 0;
    int  min_cs_high  = 1000;
    bit  gap_on       = 1'b0;
    int  gap_cyc      = 0;
    int  gap_meas     = 0;
    logic cs_q        = 1'b1;
    logic sclk_q      = 1'b1;

    always @(negedge clk) begin
        // Track how long adc_cs stays at each level.
        if (adc_cs != cs_q) begin
            if (adc_cs) begin
                last_cs_low = cs_run;
            end else if (cs_run < min_cs_high) begin
                min_cs_high = cs_run;
            end
            cs_run = 1;
        end else begin
            cs_run++;
        end

        // A falling adc_cs starts a new frame.
        if (cs_q && !adc_cs) begin
            dv_cnt    = 0;
            width_err = 0;
            low_len   = 0;
            high_on   = 1'b0;
            bit_idx   = 0;
            rx_sdi    = '0;
            gap_meas  = -1;
        end

        // Measure sclk half-periods and receive adc_sdi on each rising sclk.
        if (!adc_cs) begin
            if (!adc_sclk) begin
                if (sclk_q && high_on) begin
                    if (high_len != CLK_DIV) width_err++;
                    high_on = 1'b0;
                end
                low_len++;
            end else if (!sclk_q) begin
                if (low_len != CLK_DIV) width_err++;
                low_len  = 0;
                high_on  = 1'b1;
                high_len = 1;
                rx_sdi   = {rx_sdi[DB-2:0], adc_sdi};
                bit_idx++;
            end else if (high_on) begin
                high_len++;
            end
        end else begin
            high_on = 1'b0;
        end

        // The lanes present the bit for the next rising sclk. They carry
        // noise while the ADC is deselected.
        if (!adc_cs) begin
            if (bit_idx < DB) begin
                adc_sdo0 = word_a[DB-1-bit_idx];
                adc_sdo1 = word_b[DB-1-bit_idx];
            end
        end else begin
            adc_sdo0 = 1'($urandom);
            adc_sdo1 = 1'($urandom);
        end

        adc_rvs = rvs_auto ? (!adc_cs && cs_run >= rvs_delay) : rvs_force;

        if (data_valid) begin
            dv_cnt++;
            dv_total++;
        end

        // Count cycles from the rise of adc_cs until busy drops.
        if (!cs_q && adc_cs) begin
            gap_on  = 1'b1;
            gap_cyc = 1;
        end else if (gap_on) begin
            if (busy) begin
                gap_cyc++;
            end else begin
                gap_meas = gap_cyc;
                gap_on   = 1'b0;
            end
        end

        cs_q   = adc_cs;
        sclk_q = adc_sclk;
    end

    // -------------------------------------------------------------------------
    // Reference model: the serial link is a lossless MSB-first bit stream.
    // The word one side sends is the word the other side assembles.
    // -------------------------------------------------------------------------
    function automatic logic [DB-1:0] link_word(input logic [DB-1:0] w);
        bit            q[$];
        logic [DB-1:0] r;
        r = '0;
        for (int i = DB - 1; i >= 0; i--) q.push_back(w[i]);
        for (int i = 0; i < DB; i++) r = {r[DB-2:0], q.pop_front()};
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // One complete frame with checks
    // -------------------------------------------------------------------------
    task automatic run_frame(input string tag, input logic [DB-1:0] cfg,
                             input logic [DB-1:0] wa, input logic [DB-1:0] wb,
                             input int dly, input bit poke,
                             input logic [DB-1:0] exp_a, input logic [DB-1:0] exp_b,
                             input logic [DB-1:0] exp_rx);
        int n;
        word_a    = wa;
        word_b    = wb;
        rvs_delay = dly;
        rvs_auto  = 1'b1;
        tick();
        cfg_word = cfg;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cfg_word = DB'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_cs_low"}, 32'(adc_cs), 32'd0);
        check({tag, "_to_clear"}, 32'(timeout_err), 32'd0);
        if (poke) begin
            n = 0;
            while (bit_idx < 3 && n < 500) begin
                tick();
                n++;
            end
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_finished"}, 32'(n < 2000), 32'd1);
        check({tag, "_data_a"}, 32'(data_a), 32'(exp_a));
        check({tag, "_data_b"}, 32'(data_b), 32'(exp_b));
        check({tag, "_sdi_rx"}, 32'(rx_sdi), 32'(exp_rx));
        check({tag, "_sclk_pulses"}, 32'(bit_idx), 32'(DB));
        check({tag, "_sclk_width"}, 32'(width_err), 32'd0);
        check({tag, "_dv_count"}, 32'(dv_cnt), 32'd1);
        check({tag, "_gap_len"}, 32'(gap_meas), 32'(CS_IDLE));
        repeat (6) tick();
        check({tag, "_stays_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold_a"}, 32'(data_a), 32'(exp_a));
        check({tag, "_hold_b"}, 32'(data_b), 32'(exp_b));
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic [DB-1:0] cfg;
        logic [DB-1:0] wa;
        logic [DB-1:0] wb;
        int            dly;
        bit            poke;
        logic [DB-1:0] exp_a;
        logic [DB-1:0] exp_b;
        logic [DB-1:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int            n;
        int            dv_before;
        logic [DB-1:0] rc;
        logic [DB-1:0] ra;
        logic [DB-1:0] rb;

        vecs[0] = '{cfg: 16'h1234, wa: 16'hA5C3, wb: 16'h3C5A, dly: 10, poke: 1'b0,
                    exp_a: 16'hA5C3, exp_b: 16'h3C5A, exp_rx: 16'h1234};
        vecs[1] = '{cfg: 16'h8001, wa: 16'h0000, wb: 16'hFFFF, dly: 3, poke: 1'b0,
                    exp_a: 16'h0000, exp_b: 16'hFFFF, exp_rx: 16'h8001};
        vecs[2] = '{cfg: 16'hFFFF, wa: 16'h8001, wb: 16'h0001, dly: 1, poke: 1'b1,
                    exp_a: 16'h8001, exp_b: 16'h0001, exp_rx: 16'hFFFF};
        vecs[3] = '{cfg: 16'h0000, wa: 16'h7FFE, wb: 16'hC003, dly: 25, poke: 1'b0,
                    exp_a: 16'h7FFE, exp_b: 16'hC003, exp_rx: 16'h0000};

        // Reset values
        repeat (3) tick();
        check("rst_cs", 32'(adc_cs), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd1);
        check("rst_sdi", 32'(adc_sdi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_data_b", 32'(data_b), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven frames
        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].wa, vecs[i].wb,
                      vecs[i].dly, vecs[i].poke, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_rx);
        end

        // Randomized frames against the link model
        for (int i = 0; i < 6; i++) begin
            rc = DB'($urandom);
            ra = DB'($urandom);
            rb = DB'($urandom);
            run_frame($sformatf("rnd%0d", i), rc, ra, rb, int'($urandom_range(1, 20)), 1'b0,
                      link_word(ra), link_word(rb), link_word(rc));
        end

        // adc_rvs never arrives
`ifdef ADC_RVS_TIMEOUT_EN
        rvs_auto  = 1'b0;
        rvs_force = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check("to_finished", 32'(n < 1000), 32'd1);
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_no_dv", 32'(dv_cnt), 32'd0);
        check("to_conv_len", 32'(last_cs_low), 32'(RVS_TIMEOUT));
        check("to_gap_len", 32'(gap_meas), 32'(CS_IDLE));
        run_frame("to_recover", 16'h5AA5, 16'h1357, 16'h2468, 4, 1'b0,
                  16'h1357, 16'h2468, 16'h5AA5);
`else
        rvs_auto  = 1'b0;
        rvs_force = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (150) tick();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_cs", 32'(adc_cs), 32'd0);
        check("wait_no_timeout", 32'(timeout_err), 32'd0);
        word_a    = 16'h1357;
        word_b    = 16'h2468;
        rvs_force = 1'b1;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        rvs_force = 1'b0;
        check("wait_finished", 32'(n < 500), 32'd1);
        check("wait_dv", 32'(dv_cnt), 32'd1);
        check("wait_data_a", 32'(data_a), 32'h1357);
        check("wait_data_b", 32'(data_b), 32'h2468);
`endif

        // Reset in the middle of SHIFT, after bit 7
        word_a    = 16'hFACE;
        word_b    = 16'hBEEF;
        rvs_delay = 5;
        rvs_auto  = 1'b1;
        tick();
        cfg_word = 16'hAAAA;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (bit_idx < 8 && n < 500) begin
            tick();
            n++;
        end
        check("abort_reached_bit8", 32'(n < 500), 32'd1);
        dv_before = dv_total;
        #2;
        rst = 1'b1;
        #1;
        check("abort_cs", 32'(adc_cs), 32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd1);
        check("abort_sdi", 32'(adc_sdi), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data_a", 32'(data_a), 32'd0);
        check("abort_data_b", 32'(data_b), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("abort_no_dv", 32'(dv_total - dv_before), 32'd0);
        run_frame("after_abort", 16'hC0DE, 16'hFACE, 16'hBEEF, 6, 1'b0,
                  16'hFACE, 16'hBEEF, 16'hC0DE);

        // Back-to-back frames with start held high
        word_a      = 16'h5A5A;
        word_b      = 16'hC3C3;
        rvs_delay   = 4;
        rvs_auto    = 1'b1;
        min_cs_high = 1000;
        dv_before   = dv_total;
        cfg_word    = 16'h0F0F;
        start       = 1'b1;
        n = 0;
        while (dv_total < dv_before + 3 && n < 2000) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("b2b_frames", 32'(dv_total - dv_before), 32'd3);
        check("b2b_cs_high_min", 32'(min_cs_high >= CS_IDLE), 32'd1);
        check("b2b_data_a", 32'(data_a), 32'h5A5A);
        check("b2b_data_b", 32'(data_b), 32'hC3C3);
        check("b2b_sdi_rx", 32'(rx_sdi), 32'h0F0F);
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check("b2b_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_dual_spi_capture.md
ADC_DUAL_SPI_CAPTURE -- requirements
Module: adc_dual_spi_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, SCLK half-period in clk cycles (legal 1..255).
REQ-002 SHALL have parameter DATA_BITS, default 16, bits per conversion frame (legal 4..32).
REQ-003 SHALL have parameter CS_IDLE, default 4, minimum clk cycles adc_cs held high between frames (legal 1..255).
REQ-004 SHALL have parameter RVS_TIMEOUT, default 1024, clk cycles allowed for adc_rvs to assert (legal 2..65535).
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle conversion request.
REQ-008 SHALL have port cfg_word  input  DATA_BITS  word shifted out on adc_sdi, MSB first.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port adc_cs  output  1  ADC chip select, active low.
REQ-011 SHALL have port adc_sclk  output  1  serial clock, idle high.
REQ-012 SHALL have port adc_sdi  output  1  serial data to the ADC.
REQ-013 SHALL have port adc_sdo0 / adc_sdo1  input  1 each  ADC lane A / lane B serial data.
REQ-014 SHALL have port adc_rvs  input  1  ADC result-valid, high when conversion is complete.
REQ-015 SHALL have port data_a / data_b  output  DATA_BITS each  last captured lane A / lane B words.
REQ-016 SHALL have port data_valid  output  1  one-cycle strobe when data_a/data_b update.
REQ-017 SHALL have port timeout_err  output  1  sticky adc_rvs timeout flag.

Function
REQ-018 SHALL implement states IDLE, CONV, SHIFT and GAP, all registered.
REQ-019 In IDLE, start=1 SHALL move the block to CONV on the next edge, drive adc_cs=0, latch cfg_word and clear timeout_err.
REQ-020 start while busy=1 SHALL be ignored with no queuing.
REQ-021 adc_rvs SHALL pass through a 2-FF synchronizer; CONV SHALL exit to SHIFT on the first cycle the synchronized value is 1.
REQ-022 Each SHIFT bit SHALL be adc_sclk=0 for CLK_DIV cycles, then adc_sclk=1 for CLK_DIV cycles; exactly DATA_BITS low pulses per frame.
REQ-023 adc_sdi SHALL update at each sclk falling edge with the next latched cfg_word bit (MSB first), and SHALL be 0 outside SHIFT.
REQ-024 adc_sdo0 and adc_sdo1 SHALL be sampled on the clk edge that drives adc_sclk 0->1, and shifted MSB-first into separate registers.
REQ-025 After the DATA_BITS-th rising sclk, the next cycle SHALL update data_a/data_b, pulse data_valid=1 for exactly one cycle, set adc_cs=1 and enter GAP.
REQ-026 GAP SHALL last CS_IDLE cycles with adc_cs=1, then return to IDLE; the frame period from start to the next acceptable start is deterministic apart from the CONV wait.
REQ-027 data_a/data_b SHALL hold their value between data_valid strobes.
REQ-028 Internal counters SHALL be sized for the parameter ranges and SHALL NOT wrap within a frame.

Reset
REQ-029 rst=1 SHALL force IDLE immediately, regardless of the clk edge.
REQ-030 rst=1 SHALL set these outputs: adc_cs=1, adc_sclk=1, adc_sdi=0, busy=0, data_valid=0, data_a=0, data_b=0, timeout_err=0, and SHALL clear the synchronizer.
REQ-031 rst asserted mid-frame SHALL abort the frame with no data_valid strobe.

Configuration
REQ-032 With macro ADC_RVS_TIMEOUT_EN defined, CONV SHALL count cycles; on reaching RVS_TIMEOUT without synchronized adc_rvs, it SHALL set timeout_err=1, skip SHIFT and enter GAP with no data_valid strobe.
REQ-033 Without ADC_RVS_TIMEOUT_EN, CONV SHALL wait indefinitely and timeout_err SHALL be constant 0.

Verification
REQ-034 CLK_DIV=2, DATA_BITS=16: start, adc_rvs high 10 cycles later, sdo0 model 0xA5C3, sdo1 model 0x3C5A -> data_a=0xA5C3, data_b=0x3C5A, one data_valid pulse, 16 sclk pulses each 4 clk long.
REQ-035 cfg_word=0x8001 -> ADC model receives 0x8001 on adc_sdi at its sclk rising edges.
REQ-036 start pulsed again during SHIFT -> ignored; exactly one frame, busy low CS_IDLE=4 cycles after adc_cs rises.
REQ-037 ADC_RVS_TIMEOUT_EN defined, RVS_TIMEOUT=100, adc_rvs held 0 -> timeout_err=1 at cycle ~100, no data_valid; next start clears timeout_err.
REQ-038 rst pulsed after bit 7 of SHIFT -> adc_cs=1, adc_sclk=1, data_a/data_b=0 immediately, no data_valid; a subsequent start completes normally.
REQ-039 Back-to-back frames, start held high continuously -> new frame each IDLE entry, adc_cs high at least 4 cycles between frames.
